// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled bit timing, a one-byte holding register
// and single-cycle frame-error / overrun pulses.
module uart_rx #(
  parameter int BR   = 0,
  parameter int CLKF = 0,
  parameter int OVS  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam bit PARAM_BAD = (BR <= 0) || (CLKF <= 0) ||
                             ((CLKF % ((BR > 0) ? BR * OVS : 1)) != 0);
  localparam int DIV  = PARAM_BAD ? 1 : CLKF / (BR * OVS);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCW  = $clog2(OVS);

  localparam logic [DIVW-1:0] DIV_MAX  = DIVW'(DIV - 1);
  localparam logic [TCW-1:0]  TICK_MID = TCW'(OVS / 2 - 1);
  localparam logic [TCW-1:0]  TICK_END = TCW'(OVS - 1);

  generate
    if (PARAM_BAD) begin : g_param_check
      $fatal(1, "uart_rx: BR and CLKF must be nonzero and CLKF divisible by BR*OVS");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sync_reg;
  logic [DIVW-1:0] div_reg, div_next;
  logic [TCW-1:0]  tcnt_reg, tcnt_next;
  logic [2:0]      bcnt_reg, bcnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_reg, data_next;
  logic            valid_reg, valid_next;
  logic            ferr_reg, ferr_next;
  logic            ovr_reg, ovr_next;
  logic            rxs;
  logic            tick;
  logic            byte_done;

  assign rxs  = sync_reg[1];
  assign tick = (div_reg == DIV_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      sync_reg  <= 2'b11;
      div_reg   <= '0;
      tcnt_reg  <= '0;
      bcnt_reg  <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sync_reg  <= {sync_reg[0], rx};
      div_reg   <= div_next;
      tcnt_reg  <= tcnt_next;
      bcnt_reg  <= bcnt_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    tcnt_next  = tcnt_reg;
    bcnt_next  = bcnt_reg;
    shift_next = shift_reg;
    ferr_next  = 1'b0;
    byte_done  = 1'b0;

    // Divider and tick count only run while a frame is being timed.
    if (state_reg == S_START || state_reg == S_DATA || state_reg == S_STOP) begin
      if (tick) begin
        div_next  = '0;
        tcnt_next = tcnt_reg + TCW'(1);
      end else begin
        div_next = div_reg + DIVW'(1);
      end
    end

    unique case (state_reg)
      S_IDLE: begin
        div_next  = '0;
        tcnt_next = '0;
        bcnt_next = '0;
        if (!rxs) state_next = S_START;
      end
      S_START: begin
        if (tick && tcnt_reg == TICK_MID) begin
          tcnt_next  = '0;
          state_next = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && tcnt_reg == TICK_END) begin
          tcnt_next  = '0;
          shift_next = {rxs, shift_reg[7:1]};
          bcnt_next  = bcnt_reg + 3'd1;
          if (bcnt_reg == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (tick && tcnt_reg == TICK_END) begin
          tcnt_next = '0;
          if (rxs) begin
            byte_done  = 1'b1;
            state_next = S_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        div_next  = '0;
        tcnt_next = '0;
        if (rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Holding register: an ack in the same cycle as a new byte frees the slot.
  always_comb begin
    data_next  = data_reg;
    valid_next = valid_reg;
    ovr_next   = 1'b0;
    if (valid_reg && ack) valid_next = 1'b0;
    if (byte_done) begin
      if (!valid_reg || ack) begin
        data_next  = shift_reg;
        valid_next = 1'b1;
      end else begin
        ovr_next = 1'b1;
      end
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = ferr_reg;
  assign overrun   = ovr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven at 160 clk/bit, expected
// bytes are queued at send time and a monitor checks each holding-register load.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BR   = 115200;
  localparam int CLKF = 18432000;
  localparam int OVS  = 16;
  localparam int BITC = CLKF / BR;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.BR(BR), .CLKF(CLKF), .OVS(OVS)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ack(ack),
    .data(data), .valid(valid), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] sb[$];
  int         cyc = 0;
  int         last_start_cyc = 0;
  int         ferr_seen = 0;
  int         ovr_seen = 0;
  int         loads = 0;
  int         exp_ferr = 0;
  int         exp_ovr = 0;
  bit         auto_ack = 1'b0;
  logic       ack_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    ack_at_edge <= ack;
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Consumer: acknowledges a held byte one cycle after it appears.
  initial begin
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) ack = 1'b0;
      else if (auto_ack && valid && !ack) ack = 1'b1;
      else ack = 1'b0;
    end
  end

  // Monitor: a load is valid rising, or valid staying high across an acked edge.
  initial begin : monitor
    logic       pv, pf, po;
    logic [7:0] expb;
    int         lat;
    pv = 1'b0; pf = 1'b0; po = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && valid && (!pv || ack_at_edge)) begin
        loads++;
        lat = cyc - last_start_cyc;
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_load: got data %02h, required no load", data);
        end else begin
          expb = sb.pop_front();
          chk("load_data", int'(data), int'(expb));
          compared++;
          if (lat < 1520 || lat > 1523) begin
            mismatched++;
            $display("FAIL load_latency: got %0d clk, required 1520..1523", lat);
          end
        end
      end
      if (frame_err) begin
        ferr_seen++;
        chk("frame_err_width", int'(pf), 0);
      end
      if (overrun) begin
        ovr_seen++;
        chk("overrun_width", int'(po), 0);
      end
      pv = valid; pf = frame_err; po = overrun;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv, input int stop_len);
    @(negedge clk);
    rx = 1'b0;
    last_start_cyc = cyc;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITC) @(negedge clk);
    end
    rx = stopv;
    repeat (stop_len) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         loads_before;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_data", int'(data), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_overrun", int'(overrun), 0);
    reset = 1'b0;
    idle(20);

    // Single frame, held until the consumer takes it.
    auto_ack = 1'b1;
    sb.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, BITC);
    wait_drain();
    chk("a5_no_frame_err", ferr_seen, exp_ferr);

    // Back-to-back frames with prompt acks.
    sb.push_back(8'h3C);
    sb.push_back(8'h81);
    send_byte(8'h3C, 1'b1, BITC);
    send_byte(8'h81, 1'b1, BITC);
    wait_drain();
    chk("b2b_no_overrun", ovr_seen, exp_ovr);

    // No consumer: second byte is dropped with an overrun pulse.
    idle(10);
    auto_ack = 1'b0;
    sb.push_back(8'h11);
    send_byte(8'h11, 1'b1, BITC);
    send_byte(8'h22, 1'b1, BITC);
    exp_ovr++;
    chk("overrun_count", ovr_seen, exp_ovr);
    chk("overrun_valid_held", int'(valid), 1);
    chk("overrun_data_held", int'(data), 8'h11);
    auto_ack = 1'b1;
    idle(5);
    chk("ack_clears_valid", int'(valid), 0);

    // Bad stop bit followed by a long break, then a good frame.
    send_byte(8'h55, 1'b0, BITC);
    repeat (20 * BITC) @(negedge clk);
    exp_ferr++;
    chk("break_frame_err", ferr_seen, exp_ferr);
    chk("break_valid", int'(valid), 0);
    idle(50);
    sb.push_back(8'h0F);
    send_byte(8'h0F, 1'b1, BITC);
    wait_drain();

    // Short low glitch must be rejected.
    loads_before = loads;
    @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(400);
    chk("glitch_no_load", loads, loads_before);
    chk("glitch_no_frame_err", ferr_seen, exp_ferr);

    // Reset in the middle of a frame while a byte is held.
    auto_ack = 1'b0;
    b = 8'($urandom_range(0, 255));
    sb.push_back(b);
    send_byte(b, 1'b1, BITC);
    chk("held_before_reset", int'(valid), 1);
    @(negedge clk);
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      repeat (BITC) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BITC / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midframe_reset_valid", int'(valid), 0);
    chk("midframe_reset_data", int'(data), 0);
    chk("midframe_reset_frame_err", int'(frame_err), 0);
    chk("midframe_reset_overrun", int'(overrun), 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    loads_before = loads;
    idle(6 * BITC);
    chk("after_reset_no_load", loads, loads_before);
    auto_ack = 1'b1;
    sb.push_back(8'h99);
    send_byte(8'h99, 1'b1, BITC);
    wait_drain();

    // Random frames, some with the next start edge early in the stop bit.
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom_range(0, 255));
      sb.push_back(b);
      send_byte(b, 1'b1, $urandom_range(96, BITC));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 60));
    end
    idle(20);
    wait_drain();
    chk("final_frame_err_count", ferr_seen, exp_ferr);
    chk("final_overrun_count", ovr_seen, exp_ovr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BR, default 0, meaning serial baud rate in bits/s.
REQ-002 SHALL have parameter CLKF, default 0, meaning clk frequency in Hz.
REQ-003 SHALL have parameter OVS, default 16, meaning oversample ticks per bit (even, >=4).
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port ack  input  1  consumer acknowledge of the held byte.
REQ-008 SHALL have port data  output  8  last received byte.
REQ-009 SHALL have port valid  output  1  data holds an unacknowledged byte.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples 0.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because valid=1.

Function
REQ-012 SHALL abort elaboration with $fatal if BR==0, CLKF==0, or CLKF%(BR*OVS)!=0.
REQ-013 SHALL derive DIV=CLKF/(BR*OVS); one sample tick every DIV clk cycles (DIV=1: tick every cycle).
REQ-014 SHALL pass rx through a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value rxs.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, BREAK; frame format is 8N1, LSB first.
REQ-016 IDLE: on rxs==0, SHALL enter START with the tick divider and tick count cleared to 0.
REQ-017 START: at tick OVS/2 (mid start bit), rxs==1 SHALL return to IDLE (glitch, no outputs); rxs==0 SHALL enter DATA with the tick count cleared.
REQ-018 DATA: every OVS ticks SHALL shift rxs into bit position [7] of the shift register, shifting right; after the 8th sample, enter STOP.
REQ-019 STOP: OVS ticks after the 8th data sample, SHALL sample rxs: 1 -> byte complete, IDLE; 0 -> frame_err pulse, BREAK.
REQ-020 BREAK: SHALL stay until rxs==1, then IDLE; no start detection in BREAK.
REQ-021 On byte complete with valid==0, or with valid==1 and ack==1 on the same clk: next cycle data=byte, valid=1, no overrun.
REQ-022 On byte complete with valid==1 and ack==0: data unchanged, valid stays 1, overrun pulses for exactly one cycle.
REQ-023 valid SHALL clear on the clk edge where valid==1 and ack==1 (unless REQ-021 reloads it); ack with valid==0 SHALL be ignored.
REQ-024 data SHALL change only on a valid load; a framing error SHALL NOT modify data or valid.
REQ-025 Return to IDLE at mid stop bit SHALL allow a new start edge in the second half of the stop bit (back-to-back frames).
REQ-026 Tick divider and tick count SHALL be wide enough for DIV-1 and OVS-1 without wrap; tick count clears at each sample point.

Reset
REQ-027 Assertion of reset SHALL immediately force: state IDLE, data=0x00, valid=0, frame_err=0, overrun=0, shift register 0, counters 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL discard the partial byte; after release, reception resumes only on a new falling edge seen in IDLE.

Verification
REQ-029 BR=115200, CLKF=18432000 (DIV=10, 160 clk/bit): send 0xA5 8N1 -> valid=1, data=0xA5 within 1520+3 clk of the start edge, frame_err=0.
REQ-030 Send 0x3C then 0x81 back-to-back, ack 1 cycle after each valid -> two valid loads, data 0x3C then 0x81, no overrun.
REQ-031 Send 0x11, no ack, then send 0x22 -> overrun one-cycle pulse, data stays 0x11, valid stays 1.
REQ-032 Send 0x55 with stop bit 0, hold rx low 20 bit times -> frame_err one pulse, valid=0, no reception until rx high, then 0x0F received correctly.
REQ-033 rx low pulse of 40 clk (< half bit) -> return to IDLE, no valid, no frame_err.
REQ-034 Assert reset at bit 4 of 0xF0 -> all outputs 0 immediately; next full frame 0x99 received correctly.
